// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem every cycle and queues fetched
// {pc, instr} pairs in order for decode; supports branch redirect and halt-on-self-loop.
module fetch_ctrl #(
   parameter int unsigned  N         = 64,
   parameter int unsigned  AW        = 6,
   parameter int unsigned  DEPTH     = 2,
   parameter logic [N-1:0] RESET_PC  = '0,
   parameter logic [31:0]  HALT_WORD = 32'hb400001f
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_q,
   input  logic          redirect_valid,
   input  logic [N-1:0]  redirect_pc,
   output logic [31:0]   instr_out,
   output logic [N-1:0]  pc_out,
   output logic          valid_out,
   input  logic          ready_in,
   output logic          halted
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   pc_q, pc_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;

   logic [N-1:0]   pc_mem    [DEPTH];
   logic [31:0]    instr_mem [DEPTH];

   logic pop;
   logic fetch;

   assign imem_addr = pc_q[AW+1:2];
   assign valid_out = (count_q != '0);
   assign halted    = (state_q == StHalt);

   // Head is forced to zero when empty so decode never sees stale entries.
   assign instr_out = valid_out ? instr_mem[rd_ptr_q] : 32'h0;
   assign pc_out    = valid_out ? pc_mem[rd_ptr_q] : '0;

   assign pop   = valid_out & ready_in;
   assign fetch = (state_q == StRun) & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      if (redirect_valid) begin
         // Flush: any concurrent pop is simply dropped along with the rest of the queue.
         state_d  = StRun;
         pc_d     = redirect_pc & ~N'(3);
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (fetch) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            pc_d     = pc_q + N'(4);
            if (imem_q == HALT_WORD) begin
               state_d = StHalt;
            end
         end
         unique case ({fetch, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StRun;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Queue payload needs no reset; count gates visibility.
   always_ff @(posedge clk) begin
      if (fetch) begin
         pc_mem[wr_ptr_q]    <= pc_q;
         instr_mem[wr_ptr_q] <= imem_q;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

   localparam int unsigned N     = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] HALT  = 32'hb400001f;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_q;
   logic          redirect_valid;
   logic [N-1:0]  redirect_pc;
   logic [31:0]   instr_out;
   logic [N-1:0]  pc_out;
   logic          valid_out;
   logic          ready_in;
   logic          halted;

   logic [31:0] rom [2**AW];
   assign imem_q = rom[imem_addr];

   fetch_ctrl #(
      .N         (N),
      .AW        (AW),
      .DEPTH     (DEPTH),
      .RESET_PC  ('0),
      .HALT_WORD (HALT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst_n;
      logic        rv;
      logic [63:0] rp;
      logic        rdy;
      logic        ev;
      logic [63:0] epc;
      logic [31:0] ei;
      logic [5:0]  ea;
      logic        eh;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   function automatic logic [31:0] w(input int i);
      return 32'ha5a50000 | 32'(i);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then clock.
   task automatic apply_vec(input vec_t v, input string tag);
      reset          = v.rst_n;
      redirect_valid = v.rv;
      redirect_pc    = v.rp;
      ready_in       = v.rdy;
      @(negedge clk);
      chk({tag, " valid_out"}, 64'(valid_out), 64'(v.ev));
      chk({tag, " pc_out"},    pc_out,         v.epc);
      chk({tag, " instr_out"}, 64'(instr_out), 64'(v.ei));
      chk({tag, " imem_addr"}, 64'(imem_addr), 64'(v.ea));
      chk({tag, " halted"},    64'(halted),    64'(v.eh));
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   ent_t        mq[$];
   logic [63:0] mpc;
   bit          mhalt;

   initial begin
      for (int i = 0; i < 2**AW; i++) rom[i] = w(i);

      // Stream, stall, redirect and full-queue-redirect sequences.
      tbl.push_back('{1, 0, 64'h0,  1, 0, 64'h0,  32'h0, 6'd0,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'h0,  w(0),  6'd1,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'h4,  w(1),  6'd2,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'h8,  w(2),  6'd3,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'hc,  w(3),  6'd4,  0});
      tbl.push_back('{0, 0, 64'h0,  1, 1, 64'h10, w(4),  6'd5,  0});
      tbl.push_back('{1, 0, 64'h0,  0, 0, 64'h0,  32'h0, 6'd0,  0});
      tbl.push_back('{1, 0, 64'h0,  0, 1, 64'h0,  w(0),  6'd1,  0});
      tbl.push_back('{1, 0, 64'h0,  0, 1, 64'h0,  w(0),  6'd2,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'h0,  w(0),  6'd2,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'h4,  w(1),  6'd3,  0});
      tbl.push_back('{1, 1, 64'h23, 1, 1, 64'h8,  w(2),  6'd4,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 0, 64'h0,  32'h0, 6'd8,  0});
      tbl.push_back('{1, 0, 64'h0,  0, 1, 64'h20, w(8),  6'd9,  0});
      tbl.push_back('{1, 0, 64'h0,  0, 1, 64'h20, w(8),  6'd10, 0});
      tbl.push_back('{1, 1, 64'h8,  1, 1, 64'h20, w(8),  6'd10, 0});
      tbl.push_back('{1, 0, 64'h0,  1, 0, 64'h0,  32'h0, 6'd2,  0});
      tbl.push_back('{1, 0, 64'h0,  1, 1, 64'h8,  w(2),  6'd3,  0});

      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ready_in       = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl[%0d]", i));

      // Halt at word 4, drain, then redirect restarts fetching.
      rom[4] = HALT;
      apply_vec('{0, 0, 64'h0, 1, 1, 64'hc,  w(3),  6'd4, 0}, "halt0");
      apply_vec('{1, 0, 64'h0, 1, 0, 64'h0,  32'h0, 6'd0, 0}, "halt1");
      apply_vec('{1, 0, 64'h0, 1, 1, 64'h0,  w(0),  6'd1, 0}, "halt2");
      apply_vec('{1, 0, 64'h0, 1, 1, 64'h4,  w(1),  6'd2, 0}, "halt3");
      apply_vec('{1, 0, 64'h0, 1, 1, 64'h8,  w(2),  6'd3, 0}, "halt4");
      apply_vec('{1, 0, 64'h0, 1, 1, 64'hc,  w(3),  6'd4, 0}, "halt5");
      apply_vec('{1, 0, 64'h0, 1, 1, 64'h10, HALT,  6'd5, 1}, "halt6");
      apply_vec('{1, 0, 64'h0, 1, 0, 64'h0,  32'h0, 6'd5, 1}, "halt7");
      apply_vec('{1, 1, 64'h0, 1, 0, 64'h0,  32'h0, 6'd5, 1}, "halt8");
      apply_vec('{1, 0, 64'h0, 1, 0, 64'h0,  32'h0, 6'd0, 0}, "halt9");
      apply_vec('{1, 0, 64'h0, 1, 1, 64'h0,  w(0),  6'd1, 0}, "halt10");
      rom[4] = w(4);

      // Reset with two queued entries and pc=0x40.
      apply_vec('{1, 1, 64'h38, 0, 1, 64'h4,  w(1),  6'd2,  0}, "rst0");
      apply_vec('{1, 0, 64'h0,  0, 0, 64'h0,  32'h0, 6'd14, 0}, "rst1");
      apply_vec('{1, 0, 64'h0,  0, 1, 64'h38, w(14), 6'd15, 0}, "rst2");
      apply_vec('{0, 0, 64'h0,  0, 1, 64'h38, w(14), 6'd16, 0}, "rst3");
      apply_vec('{1, 0, 64'h0,  0, 0, 64'h0,  32'h0, 6'd0,  0}, "rst4");
      apply_vec('{1, 0, 64'h0,  0, 1, 64'h0,  w(0),  6'd1,  0}, "rst5");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 2**AW; i++) rom[i] = ($urandom_range(11) == 0) ? HALT : $urandom;
      reset          = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      mq.delete();
      mpc   = '0;
      mhalt = 1'b0;

      for (int cyc = 0; cyc < 2000; cyc++) begin
         reset          = ($urandom_range(63) != 0);
         redirect_valid = ($urandom_range(11) == 0);
         redirect_pc    = ($urandom_range(3) == 0) ? {$urandom, $urandom}
                                                   : 64'($urandom_range(255));
         ready_in       = ($urandom_range(9) < 7);
         @(negedge clk);
         chk($sformatf("rnd%0d valid_out", cyc), 64'(valid_out), 64'(mq.size() != 0));
         chk($sformatf("rnd%0d pc_out", cyc), pc_out, (mq.size() != 0) ? mq[0].pc : 64'h0);
         chk($sformatf("rnd%0d instr_out", cyc), 64'(instr_out),
             (mq.size() != 0) ? 64'(mq[0].instr) : 64'h0);
         chk($sformatf("rnd%0d imem_addr", cyc), 64'(imem_addr), (mpc >> 2) % (2**AW));
         chk($sformatf("rnd%0d halted", cyc), 64'(halted), 64'(mhalt));
         @(posedge clk);
         if (!reset) begin
            mq.delete();
            mpc   = '0;
            mhalt = 1'b0;
         end else if (redirect_valid) begin
            mq.delete();
            mpc   = redirect_pc & ~64'd3;
            mhalt = 1'b0;
         end else begin
            bit pop_m;
            bit fetch_m;
            ent_t e;
            pop_m   = (mq.size() != 0) && ready_in;
            fetch_m = !mhalt && ((mq.size() < DEPTH) || pop_m);
            if (pop_m) void'(mq.pop_front());
            if (fetch_m) begin
               e.pc    = mpc;
               e.instr = rom[(mpc >> 2) % (2**AW)];
               mq.push_back(e);
               if (e.instr == HALT) mhalt = 1'b1;
               mpc = mpc + 64'd4;
            end
         end
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the LEGv8 core; owns the PC and drives the instruction ROM address every cycle.
- Captures each fetched word into a small in-order queue and presents {pc, instr} to decode with a valid/ready handshake.
- Supports branch redirect with queue flush, and stops fetching after the program's terminating self-loop word.
- Sits between imem (combinational read, q valid in the same cycle as addr) and the decode stage.

Parameters:
- N, 64, PC width in bits.
- AW, 6, imem word-address width (ROM depth 2**AW).
- DEPTH, 2, fetch-queue entries (power of two, ≥2).
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hb400001f, encoding that ends fetching (CBZ XZR,#0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  AW  word address to imem; equals pc[AW+1:2].
- imem_q  in  32  instruction word from imem, same cycle.
- redirect_valid  in  1  branch taken; load redirect_pc.
- redirect_pc  in  N  new fetch byte address; bits [1:0] ignored (treated as 00).
- instr_out  out  32  instruction at queue head; 0 when empty.
- pc_out  out  N  byte PC of instr_out; 0 when empty.
- valid_out  out  1  queue non-empty.
- ready_in  in  1  decode accepts head this cycle.
- halted  out  1  HALT state reached.

Behaviour:
- Reset (reset==0 at an edge):
  - pc<=RESET_PC, count<=0, rd/wr pointers<=0, state<=RUN.
  - After reset: valid_out=0, instr_out=0, pc_out=0, halted=0.
  - Applies regardless of state; a mid-operation reset drops all queued entries.
- States:
  - RUN: fetching allowed.
  - HALT: no fetches; queue drains normally.
- pop = valid_out & ready_in. Removes the head at the edge.
- fetch = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
  - On fetch: enqueue {pc, imem_q} at the tail, then pc<=pc+4 (mod 2**N).
  - Enqueue and pop in the same cycle leave count unchanged.
  - No fetch when the queue is full with no pop; pc and imem_addr hold (stall).
- Latency and throughput:
  - A word fetched at edge k is visible on instr_out after edge k, if the queue was empty.
  - With ready_in=1 continuously, the block sustains one instruction per cycle.
- imem_addr is combinational from the pc register only. Upper PC bits above AW+1 are ignored, so the ROM address wraps.
- Halt:
  - If a fetched imem_q == HALT_WORD, it is enqueued normally and state<=HALT.
  - halted is registered; it goes high the cycle after that fetch.
- Redirect (highest priority, any state):
  - Queue flushed (count<=0), pc<={redirect_pc[N-1:2],2'b00}, state<=RUN, halted<=0.
  - No fetch and no enqueue that cycle. A concurrent pop is discarded (the head is consumed but irrelevant).
  - valid_out=0 on the following cycle. The first word at the new PC appears one cycle after that.
- The queue never overflows or underflows: there is no enqueue when full without a pop, and pop is gated by valid_out.
- instr_out and pc_out are forced to 0 whenever count==0.

Test Plan:
- Reset then ready_in=1, ROM words W0..W3 at 0..3 → valid_out=1 from cycle 1; pc_out 0,4,8,12 with instr_out W0..W3 on consecutive cycles; imem_addr 0,1,2,3.
- ready_in=0 from reset → after 2 cycles count=2, imem_addr holds 2, pc_out=0/instr_out=W0 stable. Raise ready_in → W0,W1,W2 streamed with no bubble.
- Steady stream at pc=0x10, pulse redirect_valid with redirect_pc=0x23 → next cycle valid_out=0, imem_addr=8; following cycle pc_out=0x20, instr_out=rom[8].
- HALT_WORD at word 4, ready_in=1 → entries pc 0..16 delivered; halted=1 the cycle after fetching pc=16; imem_addr frozen at 5; valid_out=0 after the drain. A subsequent redirect to 0 restarts fetching with halted=0.
- Queue full (ready_in=0), redirect_valid and ready_in both 1 in the same cycle → queue empties, no extra word delivered, fetch resumes at redirect_pc.
- Assert reset for one cycle with 2 queued entries and pc=0x40 → next cycle valid_out=0, imem_addr=0, halted=0; W0 appears one cycle later.
